// File: rtl/router_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_pkg: shared port IDs, arbiter state codes, round-robin helper  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package router_pkg;

  localparam int NOC_SLAVE    = 0;
  localparam int NOC_MASTER   = 1;
  localparam int AXI_SLAVE0   = 2;
  localparam int AXI_SLAVE1   = 3;
  localparam int AXI_MASTER0  = 4;
  localparam int AXI_MASTER1  = 5;

  localparam int ROUTER_PORTS = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AW   = 2'd1;
  localparam logic [1:0] ST_W    = 2'd2;

  function automatic int rr_wrap_inc(input int idx, input int ports);
    return (idx >= ports - 1) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick: first set request bit at or after ptr, wrapping modulo PORTS |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_pick
  import router_pkg::*;
#(
  parameter int PORTS = ROUTER_PORTS,
  parameter int IDX_W = 3
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int               c_sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c_sum = 0;
    cand  = '0;
    for (int i = 0; i < PORTS; i++) begin
      c_sum = int'(ptr) + i;
      if (c_sum >= PORTS) c_sum = c_sum - PORTS;
      cand = IDX_W'(c_sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_wr_arbiter: round-robin AW grant, W locked until WLAST.        |
// | Optional W-stall watchdog: define ARB_WTIMEOUT_EN.   Rev 1.0         |
// +-----------------------------------------------------------------------+
module router_wr_arbiter
  import router_pkg::*;
#(
  parameter int PORTS       = ROUTER_PORTS,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_awvalid,
  output logic [PORTS-1:0] req_awready,
  input  logic [PORTS-1:0] req_wvalid,
  output logic [PORTS-1:0] req_wready,
  input  logic [PORTS-1:0] req_wlast,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic             m_wvalid,
  input  logic             m_wready,
  output logic             m_wlast,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             err_timeout
);

  generate
    if ((1 << IDX_W) < PORTS) begin : g_bad_idx_w
      $error("IDX_W too narrow for PORTS");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be positive");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             aw_hs, w_hs;

  rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req_awvalid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Outputs depend only on state and the registered grant, never on the picker.
  always_comb begin
    req_awready = '0;
    req_wready  = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    if (state_q == ST_AW) begin
      m_awvalid                = req_awvalid[grant_idx_q];
      req_awready[grant_idx_q] = m_awready;
    end
    if (state_q == ST_W) begin
      m_wvalid                = req_wvalid[grant_idx_q];
      m_wlast                 = req_wlast[grant_idx_q];
      req_wready[grant_idx_q] = m_wready;
    end
  end

  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == ST_AW) || (state_q == ST_W);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = ST_AW;
        end
      end
      ST_AW: begin
        if (aw_hs) begin
          rr_ptr_d = IDX_W'(rr_wrap_inc(int'(grant_idx_q), PORTS));
          state_d  = ST_W;
        end
      end
      ST_W: begin
        if (w_hs && m_wlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

`ifdef ARB_WTIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_timeout_q, err_timeout_d;

  // Counts cycles the granted source starves the W channel; saturates at the limit.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (aw_hs) begin
      to_cnt_d = '0;
    end else if (state_q == ST_W) begin
      if (w_hs)
        to_cnt_d = '0;
      else if (!m_wvalid && (to_cnt_q != TO_W'(TIMEOUT_CYC)))
        to_cnt_d = to_cnt_q + 1'b1;
    end
    err_timeout_d = err_timeout_q | (to_cnt_d == TO_W'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_router_wr_arbiter: directed vectors for the write-channel arbiter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_router_wr_arbiter;

  localparam int PORTS = 6;
  localparam int IDX_W = 3;
`ifdef ARB_WTIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [PORTS-1:0] req_awvalid, req_awready, req_wvalid, req_wready, req_wlast;
  logic             m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [IDX_W-1:0] grant_idx;
  logic             busy, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  router_wr_arbiter #(.PORTS(PORTS), .IDX_W(IDX_W), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_awvalid (req_awvalid),
    .req_awready (req_awready),
    .req_wvalid  (req_wvalid),
    .req_wready  (req_wready),
    .req_wlast   (req_wlast),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_wlast     (m_wlast),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_awvalid = '0;
    req_wvalid  = '0;
    req_wlast   = '0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic do_burst(input logic [PORTS-1:0] aw_req, input int exp_idx, input int beats);
    logic [PORTS-1:0] oh;
    oh = PORTS'(1) << exp_idx;
    req_awvalid = aw_req;
    req_wvalid  = '0;
    req_wlast   = '0;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    #1;
    chk("idle_awvalid", 32'(m_awvalid), 32'd0);
    tick();
    chk("grant_idx", 32'(grant_idx), 32'(exp_idx));
    chk("aw_valid", 32'(m_awvalid), 32'd1);
    chk("aw_ready_onehot", 32'(req_awready), 32'(oh));
    tick();
    for (int b = 0; b < beats; b++) begin
      req_wvalid = oh;
      req_wlast  = (b == beats - 1) ? oh : '0;
      #1;
      chk("w_valid", 32'(m_wvalid), 32'd1);
      chk("w_ready_onehot", 32'(req_wready), 32'(oh));
      chk("w_last", 32'(m_wlast), (b == beats - 1) ? 32'd1 : 32'd0);
      tick();
    end
    req_wvalid = '0;
    req_wlast  = '0;
    #1;
    chk("post_burst_state", 32'(dut.state_q), 32'd0);
    chk("post_burst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_wvalid), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    tick();
    chk("no_req_busy", 32'(busy), 32'd0);

    // single 4-beat burst from input 2
    do_burst(6'b000100, 2, 4);
    chk("rr_ptr_after_2", 32'(dut.rr_ptr_q), 32'd3);

    // fairness from a fresh pointer
    apply_reset();
    for (int k = 0; k < 7; k++) do_burst(6'b111111, k % 6, 1);

    // pointer wrap: serve 4, then 5 and 0 compete
    do_burst(6'b010000, 4, 1);
    chk("rr_ptr_5", 32'(dut.rr_ptr_q), 32'd5);
    do_burst(6'b100001, 5, 1);
    do_burst(6'b100001, 0, 1);

    // AW backpressure with early W from input 1
    req_awvalid = 6'b000010;
    req_wvalid  = 6'b000010;
    req_wlast   = 6'b000010;
    m_awready   = 1'b0;
    m_wready    = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_awvalid", 32'(m_awvalid), 32'd1);
      chk("bp_grant", 32'(grant_idx), 32'd1);
      chk("bp_wready", 32'(req_wready), 32'd0);
      chk("bp_wvalid", 32'(m_wvalid), 32'd0);
      chk("bp_awready", 32'(req_awready), 32'd0);
      tick();
    end
    m_awready = 1'b1;
    #1;
    chk("bp_awready_hs", 32'(req_awready), 32'b000010);
    tick();
    req_awvalid = '0;
    #1;
    chk("bp_w_ready", 32'(req_wready), 32'b000010);
    chk("bp_w_valid", 32'(m_wvalid), 32'd1);
    tick();
    chk("bp_done", 32'(busy), 32'd0);
    req_wvalid = '0;
    req_wlast  = '0;

    // reset in the middle of a 4-beat burst from input 4
    req_awvalid = 6'b010000;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    tick();
    chk("mid_grant", 32'(grant_idx), 32'd4);
    tick();
    req_awvalid = '0;
    req_wvalid  = 6'b010000;
    repeat (2) tick();
    chk("mid_wready_before", 32'(req_wready), 32'b010000);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wready", 32'(req_wready), 32'd0);
    chk("mid_rst_wvalid", 32'(m_wvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_idx), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'd0);
    chk("mid_rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    tick();
    idle_inputs();
    rst = 1'b0;
    do_burst(6'b101000, 3, 1);
    chk("rr_ptr_after_3", 32'(dut.rr_ptr_q), 32'd4);

    // W starvation: grant taken, source silent
    req_awvalid = 6'b000001;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    tick();
    tick();
    req_awvalid = '0;
    repeat (7) tick();
    chk("to_before", 32'(err_timeout), 32'd0);
    tick();
    chk("to_set", 32'(err_timeout), 32'(EXP_TO));
    chk("to_busy", 32'(busy), 32'd1);
    req_wvalid = 6'b000001;
    req_wlast  = 6'b000001;
    tick();
    req_wvalid = '0;
    req_wlast  = '0;
    repeat (3) tick();
    chk("to_sticky", 32'(err_timeout), 32'(EXP_TO));
    chk("to_idle", 32'(busy), 32'd0);
    apply_reset();
    chk("to_cleared", 32'(err_timeout), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
